mem_stage_dmem: RTL
===================

# mem_stage_dmem

Data-memory block for the MEM stage of the 64-bit RV64I five-stage pipeline. It takes the address, store data and memory controls from the EX/MEM pipeline register and performs little-endian, byte-addressable loads and stores of every RV64I width. Load data is returned to the MEM/WB register in the same cycle it completes. An optional wait-state FSM produces a `stall` to freeze the upstream stages, and misaligned, out-of-range and illegal accesses are recorded in sticky fault registers.

## Interface
- DEPTH_BYTES, 256 — memory size in bytes; must be a power of two, ≥ 8.
- WAIT_STATES, 0 — extra cycles per valid access, range 0–15.

Ports:
- clk  input  1  — clock, all state updates on the rising edge.
- reset  input  1  — synchronous, active-high.
- memread  input  1  — load request.
- memwrite  input  1  — store request.
- funct3  input  3  — access size and signedness.
- addr  input  64  — byte address, taken from the ALU result.
- wdata  input  64  — store data, taken from the forwarded rs2 value.
- rdata  output  64  — load result, sign- or zero-extended.
- stall  output  1  — upstream must hold all inputs steady.
- fault  output  1  — sticky access fault.
- fault_addr  output  64  — address of the first faulting access.

## Operation
- A request is `memread | memwrite`. If both are high, the access is illegal.
- **Load funct3:** 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu. 111 is illegal.
- **Store funct3:** 000 sb, 001 sh, 010 sw, 011 sd. 1xx is illegal.
- **Index:** `addr[AW-1:0]`, where AW = log2(DEPTH_BYTES).
- **Out of range:** any of `addr[63:AW]` nonzero.
- **Misaligned:** addr not a multiple of the access size.
- **Faulting access** (illegal, out of range, or misaligned):
  - No memory write; rdata = 0.
  - No wait states; stall stays 0.
  - On the next edge, fault is set to 1. fault_addr takes addr only if fault was 0.
- **Stores:** write the low 1/2/4/8 bytes of wdata at index upward (byte 0 at the lowest address) on the completion edge.
- **Loads:** rdata is combinational from the array in the completion cycle. It is extended per funct3 to 64 bits.
- rdata = 0 whenever no load is completing.
- **FSM** (counter `cnt`, 4 bits):
  - IDLE, with a valid request and WAIT_STATES = 0: the access completes this cycle; stay in IDLE.
  - IDLE, with a valid request and WAIT_STATES > 0: stall = 1; next state WAIT with cnt ← WAIT_STATES−1.
  - WAIT, cnt ≠ 0: stall = 1; cnt decrements.
  - WAIT, cnt = 0: stall = 0; the access completes (load data driven, store committed at the edge); next state IDLE.
  - A new request seen in IDLE always starts fresh, with no back-to-back overlap.
- **Reset:**
  - Array cleared to 0; state IDLE; cnt = 0; fault = 0; fault_addr = 0.
  - While reset is high: stall = 0, rdata = 0, no write.
  - Reset during WAIT abandons the access. Any pending store is discarded.

## Timing
- Request presented in cycle T:
  - stall is high in cycles T … T+WAIT_STATES−1 and low in T+WAIT_STATES.
  - rdata is valid in cycle T+WAIT_STATES.
  - Store data is visible to a load starting in cycle T+WAIT_STATES+1.
- With WAIT_STATES = 0, latency is combinational and the EX/MEM→MEM/WB path is a single cycle.
- stall is a combinational function of state, cnt, the request and the fault check. There is no input-to-stall path other than the request and fault decode.
- fault and fault_addr change only on clock edges. Only reset clears fault.

## Test plan
- **sd/ld round trip** (WAIT_STATES = 0):
  - sd wdata=0x1122334455667788 to addr 0x10, then ld from 0x10 → rdata=0x1122334455667788.
  - lbu 0x10 → 0x88.
  - lh 0x16 → 0x1122.
- **Sign extension:**
  - sb 0x80 to 0x21; lb 0x21 → 0xFFFFFFFFFFFFFF80; lbu 0x21 → 0x80.
  - sw 0xDEADBEEF to 0x24; lw → 0xFFFFFFFFDEADBEEF; lwu → 0x00000000DEADBEEF.
- **Wait states** (WAIT_STATES = 3):
  - ld issued at cycle T → stall high for T, T+1, T+2 and low at T+3.
  - rdata is valid only at T+3.
  - A sw issued at T is not visible before T+4.
- **Faults:**
  - ld at 0x13 (misaligned) → no wait, rdata=0; fault=1 and fault_addr=0x13 next cycle.
  - sd at 0x1000 (out of range) afterwards → fault_addr stays 0x13.
  - memread=memwrite=1 → fault set, no write.
- **Reset mid-wait** (WAIT_STATES = 3):
  - sd to 0x08 at T, reset at T+1 → stall=0 during reset.
  - ld 0x08 after reset → 0; fault=0.
- **Partial store merge:**
  - sd 0xFFFFFFFFFFFFFFFF to 0x30, then sh 0x1234 to 0x32 → ld 0x30 = 0xFFFFFFFF1234FFFF.

Source files
------------

// File: rtl/mem_stage_dmem_if.sv
// MEM-stage data-memory bus: EX/MEM request side and MEM/WB response side.
interface mem_stage_dmem_if;
  logic        memread;
  logic        memwrite;
  logic [2:0]  funct3;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        stall;
  logic        fault;
  logic [63:0] fault_addr;

  // Pipeline side: issues requests, consumes load data, stall and fault.
  modport master (
    output memread, memwrite, funct3, addr, wdata,
    input  rdata, stall, fault, fault_addr
  );

  // Memory side.
  modport slave (
    input  memread, memwrite, funct3, addr, wdata,
    output rdata, stall, fault, fault_addr
  );
endinterface

// File: rtl/mem_stage_dmem.sv
// RV64I MEM-stage data memory: little-endian byte-addressed loads/stores of
// every width, optional wait-state FSM driving stall, sticky fault capture.
module mem_stage_dmem #(
  parameter int DEPTH_BYTES = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            reset,
  mem_stage_dmem_if.slave bus
);
  localparam int          AW      = $clog2(DEPTH_BYTES);
  localparam int          LANES   = 8;
  localparam logic [3:0]  CNT_INI = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic { S_IDLE, S_WAIT } state_t;

  state_t      state, nstate;
  logic [3:0]  cnt, ncnt;
  logic [7:0]  mem [DEPTH_BYTES];

  logic            req, illegal, oor, mis, bad, valid;
  logic            complete, stall;
  logic [2:0]      amask;
  logic [AW-1:0]   idx;
  logic [LANES-1:0]          lane_en;
  logic [LANES-1:0][AW-1:0]  lane_idx;
  logic [LANES-1:0][7:0]     rd_byte;
  logic [63:0]     raw, ext;
  logic            fault_q;
  logic [63:0]     fault_addr_q;

  assign req = bus.memread | bus.memwrite;
  assign idx = bus.addr[AW-1:0];

  // Access-size decode: byte offset mask for 1/2/4/8-byte accesses.
  always_comb begin
    amask = 3'd0;
    case (bus.funct3[1:0])
      2'd0: amask = 3'd0;
      2'd1: amask = 3'd1;
      2'd2: amask = 3'd3;
      2'd3: amask = 3'd7;
      default: amask = 3'd0;
    endcase
  end

  // Fault decode; a faulting access never waits and never touches the array.
  assign illegal = (bus.memread & bus.memwrite)
                 | (bus.memread  & (bus.funct3 == 3'b111))
                 | (bus.memwrite & bus.funct3[2]);
  assign oor     = |bus.addr[63:AW];
  assign mis     = |(bus.addr[2:0] & amask);
  assign bad     = req & (illegal | oor | mis);
  assign valid   = req & ~bad;

  // Per-byte lanes: lane i covers index+i; aligned accesses never wrap.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_en[i]      = (3'(i) <= amask);
    assign lane_idx[i]     = idx + AW'(i);
    assign rd_byte[i]      = mem[lane_idx[i]];
    assign raw[8*i +: 8]   = rd_byte[i];
  end

  // State register: FSM state and wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
    end
  end

  // Next-state logic: every IDLE request starts a fresh countdown.
  always_comb begin
    nstate = state;
    ncnt   = cnt;
    case (state)
      S_IDLE: begin
        if (valid && (WAIT_STATES != 0)) begin
          nstate = S_WAIT;
          ncnt   = CNT_INI;
        end
      end
      S_WAIT: begin
        if (!valid) begin
          nstate = S_IDLE;
          ncnt   = 4'd0;
        end else if (cnt != 4'd0) begin
          ncnt   = cnt - 4'd1;
        end else begin
          nstate = S_IDLE;
        end
      end
      default: begin
        nstate = S_IDLE;
        ncnt   = 4'd0;
      end
    endcase
  end

  // Output logic: stall while counting, complete on the last cycle.
  always_comb begin
    stall    = 1'b0;
    complete = 1'b0;
    if (!reset && valid) begin
      case (state)
        S_IDLE: begin
          if (WAIT_STATES == 0) complete = 1'b1;
          else                  stall    = 1'b1;
        end
        S_WAIT: begin
          if (cnt != 4'd0) stall    = 1'b1;
          else             complete = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Load extension per funct3.
  always_comb begin
    ext = 64'd0;
    case (bus.funct3)
      3'b000: ext = {{56{raw[7]}},  raw[7:0]};
      3'b001: ext = {{48{raw[15]}}, raw[15:0]};
      3'b010: ext = {{32{raw[31]}}, raw[31:0]};
      3'b011: ext = raw;
      3'b100: ext = {56'd0, raw[7:0]};
      3'b101: ext = {48'd0, raw[15:0]};
      3'b110: ext = {32'd0, raw[31:0]};
      default: ext = 64'd0;
    endcase
  end

  // Array: cleared by reset, store bytes committed on the completion edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < DEPTH_BYTES; j++) mem[j] <= 8'd0;
    end else if (complete && bus.memwrite) begin
      for (int i = 0; i < LANES; i++)
        if (lane_en[i]) mem[lane_idx[i]] <= bus.wdata[8*i +: 8];
    end
  end

  // Sticky fault; address captured only for the first fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q      <= 1'b0;
      fault_addr_q <= 64'd0;
    end else if (bad) begin
      fault_q <= 1'b1;
      if (!fault_q) fault_addr_q <= bus.addr;
    end
  end

  assign bus.rdata      = (complete && bus.memread) ? ext : 64'd0;
  assign bus.stall      = stall;
  assign bus.fault      = fault_q;
  assign bus.fault_addr = fault_addr_q;
endmodule
